lcd_nibble_receiver: RTL and testbench

Receiving end of the 4-bit HD44780-style character-LCD bus (LCDE/LCDRS/LCDRW/LCDDAT) that our display driver transmits on. It follows the 4-bit initialisation sequence, reassembles nibble pairs into bytes, and executes the command subset the driver uses. Characters are kept in a 32-entry shadow DDRAM (2×16) that a bench or on-chip checker can read back. It is used as a bus monitor/responder when verifying the display path and the pipeline-status strings.

---
 rtl/lcd_nibble_receiver.sv | 223 ++++++++++++++++++++++
 tb/tb_lcd_nibble_receiver.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: receiving end of a 4-bit HD44780-style LCD bus.
// Follows the 4-bit init sequence, pairs nibbles into bytes, executes the
// command subset the display driver uses, and keeps a 2x16 shadow DDRAM in
// flops that can be read back through a registered read port.
module lcd_nibble_receiver (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [3:0] lcd_dat,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       byte_valid,
  output logic       byte_is_data,
  output logic [7:0] last_byte,
  output logic [4:0] cursor,
  output logic       init_done,
  output logic       disp_on,
  output logic       busy,
  output logic       err
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  // Synchroniser chain, bus order {e, rs, rw, dat[3:0]}
  logic [6:0] sync1_q, sync2_q;
  logic       e_prev_q;

  state_t     state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic       hi_rs_q, hi_rs_d;
  logic       id_q, id_d;
  logic [4:0] cursor_q, cursor_d;
  logic [7:0] mem_q [32];
  logic [7:0] mem_d [32];
  logic       busy_q, busy_d;
  logic [4:0] clr_cnt_q, clr_cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic [7:0] last_byte_q, last_byte_d;
  logic       init_done_q, init_done_d;
  logic       disp_on_q, disp_on_d;
  logic       err_q, err_d;
  logic [7:0] rd_char_q, rd_char_d;

  logic       e_s, rs_s, rw_s, strobe_s;
  logic [3:0] dat_s;
  logic [7:0] byte_s;

  assign e_s      = sync2_q[6];
  assign rs_s     = sync2_q[5];
  assign rw_s     = sync2_q[4];
  assign dat_s    = sync2_q[3:0];
  // Falling edge of the synchronised enable is the sampling point
  assign strobe_s = e_prev_q & ~e_s;
  assign byte_s   = {hi_q, dat_s};

  // Two-flop synchronisers for all bus inputs plus the previous-E flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 7'd0;
      sync2_q  <= 7'd0;
      e_prev_q <= 1'b0;
    end else begin
      sync1_q  <= {lcd_e, lcd_rs, lcd_rw, lcd_dat};
      sync2_q  <= sync1_q;
      e_prev_q <= e_s;
    end
  end

  // Next-state logic: clear engine, init/nibble FSM and byte execution
  always_comb begin
    state_d        = state_q;
    hi_d           = hi_q;
    hi_rs_d        = hi_rs_q;
    id_d           = id_q;
    cursor_d       = cursor_q;
    mem_d          = mem_q;
    busy_d         = busy_q;
    clr_cnt_d      = clr_cnt_q;
    byte_valid_d   = 1'b0;
    byte_is_data_d = byte_is_data_q;
    last_byte_d    = last_byte_q;
    init_done_d    = init_done_q;
    disp_on_d      = disp_on_q;
    err_d          = err_q;
    rd_char_d      = mem_q[rd_addr];

    // Clear engine: one cell per clk, finishing with cursor home and I/D=1
    if (busy_q) begin
      mem_d[clr_cnt_q] = 8'h20;
      if (clr_cnt_q == 5'd31) begin
        busy_d    = 1'b0;
        clr_cnt_d = 5'd0;
        cursor_d  = 5'd0;
        id_d      = 1'b1;
      end else begin
        clr_cnt_d = clr_cnt_q + 5'd1;
      end
    end else begin
      clr_cnt_d = clr_cnt_q;
    end

    if (strobe_s) begin
      if (rw_s) begin
        // Reads are not supported: flag and leave all state alone
        err_d = 1'b1;
      end else begin
        case (state_q)
          S_INIT: begin
            if (!rs_s && (dat_s == 4'h2)) begin
              state_d     = S_HI;
              init_done_d = 1'b1;
            end else if (!rs_s && (dat_s == 4'h3)) begin
              state_d = S_INIT;
            end else begin
              err_d = 1'b1;
            end
          end
          S_HI: begin
            hi_d    = dat_s;
            hi_rs_d = rs_s;
            state_d = S_LO;
          end
          S_LO: begin
            state_d = S_HI;
            if (busy_q || (rs_s != hi_rs_q)) begin
              err_d = 1'b1;
            end else begin
              byte_valid_d   = 1'b1;
              last_byte_d    = byte_s;
              byte_is_data_d = rs_s;
              if (rs_s) begin
                mem_d[cursor_q] = byte_s;
                cursor_d = id_q ? (cursor_q + 5'd1) : (cursor_q - 5'd1);
              end else if (byte_s == 8'h01) begin
                busy_d    = 1'b1;
                clr_cnt_d = 5'd0;
              end else if (byte_s[7:1] == 7'h01) begin
                cursor_d = 5'd0;
              end else if (byte_s[7:2] == 6'h01) begin
                id_d = byte_s[1];
              end else if (byte_s[7:3] == 5'h01) begin
                disp_on_d = byte_s[2];
              end else if (byte_s[7] == 1'b0) begin
                // Shift / function set / CGRAM address / 0x00: no effect
                cursor_d = cursor_q;
              end else if (byte_s[7:4] == 4'h8) begin
                cursor_d = {1'b0, byte_s[3:0]};
              end else if (byte_s[7:4] == 4'hC) begin
                cursor_d = {1'b1, byte_s[3:0]};
              end else begin
                err_d = 1'b1;
              end
            end
          end
          default: begin
            state_d = S_INIT;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, shadow DDRAM and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_INIT;
      hi_q           <= 4'h0;
      hi_rs_q        <= 1'b0;
      id_q           <= 1'b1;
      cursor_q       <= 5'd0;
      busy_q         <= 1'b0;
      clr_cnt_q      <= 5'd0;
      byte_valid_q   <= 1'b0;
      byte_is_data_q <= 1'b0;
      last_byte_q    <= 8'h00;
      init_done_q    <= 1'b0;
      disp_on_q      <= 1'b0;
      err_q          <= 1'b0;
      rd_char_q      <= 8'h20;
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= 8'h20;
      end
    end else begin
      state_q        <= state_d;
      hi_q           <= hi_d;
      hi_rs_q        <= hi_rs_d;
      id_q           <= id_d;
      cursor_q       <= cursor_d;
      busy_q         <= busy_d;
      clr_cnt_q      <= clr_cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_is_data_q <= byte_is_data_d;
      last_byte_q    <= last_byte_d;
      init_done_q    <= init_done_d;
      disp_on_q      <= disp_on_d;
      err_q          <= err_d;
      rd_char_q      <= rd_char_d;
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_char      = rd_char_q;
  assign byte_valid   = byte_valid_q;
  assign byte_is_data = byte_is_data_q;
  assign last_byte    = last_byte_q;
  assign cursor       = cursor_q;
  assign init_done    = init_done_q;
  assign disp_on      = disp_on_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Bench for lcd_nibble_receiver: drives randomized LCD bus traffic and
// compares the DUT against a byte-level behavioural model of the display.
module tb_lcd_nibble_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic [3:0] lcd_dat = 4'h0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic       byte_valid;
  logic       byte_is_data;
  logic [7:0] last_byte;
  logic [4:0] cursor;
  logic       init_done;
  logic       disp_on;
  logic       busy;
  logic       err;

  int errors = 0;
  int checks = 0;

  lcd_nibble_receiver dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_dat(lcd_dat), .rd_addr(rd_addr), .rd_char(rd_char),
    .byte_valid(byte_valid), .byte_is_data(byte_is_data),
    .last_byte(last_byte), .cursor(cursor), .init_done(init_done),
    .disp_on(disp_on), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Pulse/cycle counters sampled on the falling edge
  int bv_cnt = 0;
  int bv_data_cnt = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (byte_valid) bv_cnt <= bv_cnt + 1;
    if (byte_valid && byte_is_data) bv_data_cnt <= bv_data_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // ---------------- behavioural model (display-level view) ----------------
  logic [7:0] mem_m [32];
  logic [4:0] cur_m;
  bit         id_m, disp_m, init_m, err_m, busy_m, have_hi_m, hi_rs_m, isdata_m;
  logic [3:0] hi_m;
  logic [7:0] last_m;
  logic [7:0] dut_mem [32];

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h20;
    cur_m = 5'd0; id_m = 1'b1; disp_m = 1'b0; init_m = 1'b0; err_m = 1'b0;
    busy_m = 1'b0; have_hi_m = 1'b0; hi_rs_m = 1'b0; isdata_m = 1'b0;
    hi_m = 4'h0; last_m = 8'h00;
  endtask

  task automatic model_cmd(input logic [7:0] b);
    if (b == 8'h01) begin
      for (int i = 0; i < 32; i++) mem_m[i] = 8'h20;
      cur_m = 5'd0; id_m = 1'b1; busy_m = 1'b1;
    end else if (b inside {[8'h02:8'h03]}) cur_m = 5'd0;
    else if (b inside {[8'h04:8'h07]}) id_m = b[1];
    else if (b inside {[8'h08:8'h0F]}) disp_m = b[2];
    else if (b inside {[8'h80:8'h8F]}) cur_m = 5'(int'(b) - 128);
    else if (b inside {[8'hC0:8'hCF]}) cur_m = 5'(int'(b) - 192 + 16);
    else if (b >= 8'h80) err_m = 1'b1;
  endtask

  task automatic model_strobe(input bit rs, input bit rw, input logic [3:0] dat);
    logic [7:0] b;
    if (rw) err_m = 1'b1;
    else if (!init_m) begin
      if (!rs && dat == 4'h2) init_m = 1'b1;
      else if (!(!rs && dat == 4'h3)) err_m = 1'b1;
    end else if (!have_hi_m) begin
      hi_m = dat; hi_rs_m = rs; have_hi_m = 1'b1;
    end else begin
      have_hi_m = 1'b0;
      b = {hi_m, dat};
      if (busy_m || rs != hi_rs_m) err_m = 1'b1;
      else begin
        last_m = b; isdata_m = rs;
        if (rs) begin
          mem_m[cur_m] = b;
          cur_m = id_m ? cur_m + 5'd1 : cur_m - 5'd1;
        end else model_cmd(b);
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_nibble(input bit rs, input bit rw, input logic [3:0] dat, input bit fast);
    int hi_n, lo_n;
    hi_n = fast ? 2 : 2 + $urandom_range(0, 2);
    lo_n = fast ? 5 : 5 + $urandom_range(0, 3);
    @(negedge clk);
    lcd_rs = rs; lcd_rw = rw; lcd_dat = dat; lcd_e = 1'b1;
    repeat (hi_n) @(negedge clk);
    lcd_e = 1'b0;
    repeat (lo_n) @(negedge clk);
    model_strobe(rs, rw, dat);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b, input bit fast);
    send_nibble(rs, 1'b0, b[7:4], fast);
    send_nibble(rs, 1'b0, b[3:0], fast);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; lcd_e = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_init();
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h2, 1'b0);
  endtask

  task automatic wait_clear();
    repeat (40) @(negedge clk);
    busy_m = 1'b0;
  endtask

  task automatic dump_mem();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk); rd_addr = 5'(i);
      @(negedge clk); dut_mem[i] = rd_char;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if ({byte_valid, byte_is_data, init_done, disp_on, busy, err} !== 6'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 000000",
        {byte_valid, byte_is_data, init_done, disp_on, busy, err});
    end
    checks++;
    if (last_byte !== 8'h00 || cursor !== 5'd0 || rd_char !== 8'h20) begin
      errors++; $display("FAIL reset_values: last=%h cur=%0d rd=%h want 00 0 20",
        last_byte, cursor, rd_char);
    end
  endtask

  task automatic test_init();
    int bv0;
    bv0 = bv_cnt;
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    send_nibble(1'b0, 1'b0, 4'h3, 1'b0);
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL init_early: got %b want 0", init_done); end
    send_nibble(1'b0, 1'b0, 4'h2, 1'b0);
    checks++;
    if (init_done !== 1'b1 || err !== 1'b0) begin
      errors++; $display("FAIL init_done: init=%b err=%b want 1 0", init_done, err);
    end
    checks++;
    if (bv_cnt - bv0 != 0) begin errors++; $display("FAIL init_no_bv: got %0d want 0", bv_cnt - bv0); end
  endtask

  task automatic test_line2_write();
    int bvd0;
    bvd0 = bv_data_cnt;
    send_byte(1'b0, 8'hC0, 1'b0);
    send_byte(1'b1, 8'h41, 1'b0);
    send_byte(1'b1, 8'h42, 1'b0);
    checks++;
    if (bv_data_cnt - bvd0 != 2) begin errors++; $display("FAIL line2_bv: got %0d want 2", bv_data_cnt - bvd0); end
    checks++;
    if (cursor !== 5'd18 || cursor !== cur_m) begin errors++; $display("FAIL line2_cursor: got %0d want 18", cursor); end
    checks++;
    if (last_byte !== 8'h42 || byte_is_data !== 1'b1) begin
      errors++; $display("FAIL line2_last: got %h/%b want 42/1", last_byte, byte_is_data);
    end
    @(negedge clk); rd_addr = 5'd17;
    @(negedge clk);
    checks++;
    if (rd_char !== 8'h42) begin errors++; $display("FAIL line2_rd17: got %h want 42", rd_char); end
    rd_addr = 5'd16;
    @(negedge clk);
    checks++;
    if (rd_char !== 8'h41) begin errors++; $display("FAIL line2_rd16: got %h want 41", rd_char); end
  endtask

  task automatic test_wrap_decrement();
    logic [7:0] c;
    send_byte(1'b0, 8'h8F, 1'b0);
    send_byte(1'b1, 8'h78, 1'b0);
    send_byte(1'b0, 8'hCF, 1'b0);
    send_byte(1'b1, 8'h79, 1'b0);
    checks++;
    if (cursor !== 5'd0) begin errors++; $display("FAIL wrap_cursor: got %0d want 0", cursor); end
    c = 8'(8'h21 + $urandom_range(0, 90));
    send_byte(1'b0, 8'h04, 1'b0);
    send_byte(1'b1, c, 1'b0);
    checks++;
    if (cursor !== 5'd31) begin errors++; $display("FAIL decr_cursor: got %0d want 31", cursor); end
    dump_mem();
    checks++;
    if (dut_mem[15] !== 8'h78 || dut_mem[31] !== 8'h79 || dut_mem[0] !== c) begin
      errors++; $display("FAIL wrap_mem: got %h %h %h want 78 79 %h", dut_mem[15], dut_mem[31], dut_mem[0], c);
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] b;
    bit rs;
    send_byte(1'b0, 8'h06, 1'b0);
    for (int n = 0; n < 24; n++) begin
      rs = 1'b0;
      case ($urandom_range(0, 5))
        0, 1:    begin rs = 1'b1; b = 8'(8'h20 + $urandom_range(0, 94)); end
        2:       b = 8'(8'h80 + $urandom_range(0, 15));
        3:       b = 8'(8'hC0 + $urandom_range(0, 15));
        4:       b = 8'(8'h04 + $urandom_range(0, 3));
        default: b = 8'(8'h08 + $urandom_range(0, 7));
      endcase
      send_byte(rs, b, 1'b0);
      checks++;
      if (cursor !== cur_m) begin errors++; $display("FAIL rand_cursor[%0d]: got %0d want %0d", n, cursor, cur_m); end
    end
    checks++;
    if (disp_on !== disp_m || last_byte !== last_m || byte_is_data !== isdata_m || err !== err_m) begin
      errors++; $display("FAIL rand_state: disp=%b last=%h data=%b err=%b want %b %h %b %b",
        disp_on, last_byte, byte_is_data, err, disp_m, last_m, isdata_m, err_m);
    end
    dump_mem();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut_mem[i] !== mem_m[i]) begin errors++; $display("FAIL rand_mem[%0d]: got %h want %h", i, dut_mem[i], mem_m[i]); end
    end
  endtask

  task automatic test_clear();
    int b0, bvd0;
    send_byte(1'b0, 8'h85, 1'b0);
    b0 = busy_cnt;
    send_byte(1'b0, 8'h01, 1'b0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b want 1", busy); end
    wait_clear();
    checks++;
    if (busy_cnt - b0 != 32) begin errors++; $display("FAIL clear_len: got %0d want 32", busy_cnt - b0); end
    checks++;
    if (cursor !== 5'd0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL clear_end: cur=%0d busy=%b err=%b want 0 0 0", cursor, busy, err);
    end
    dump_mem();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut_mem[i] !== 8'h20) begin errors++; $display("FAIL clear_mem[%0d]: got %h want 20", i, dut_mem[i]); end
    end
    // A data byte completing while the clear runs is dropped
    send_byte(1'b1, 8'h51, 1'b0);
    bvd0 = bv_data_cnt;
    send_byte(1'b0, 8'h01, 1'b1);
    send_byte(1'b1, 8'h55, 1'b1);
    wait_clear();
    checks++;
    if (err !== 1'b1 || err_m !== 1'b1) begin errors++; $display("FAIL clear_drop_err: got %b want 1", err); end
    checks++;
    if (bv_data_cnt - bvd0 != 0 || cursor !== cur_m) begin
      errors++; $display("FAIL clear_drop: bv=%0d cur=%0d want 0 %0d", bv_data_cnt - bvd0, cursor, cur_m);
    end
    dump_mem();
    checks++;
    if (dut_mem[0] !== 8'h20 || dut_mem[1] !== 8'h20) begin
      errors++; $display("FAIL clear_drop_mem: got %h %h want 20 20", dut_mem[0], dut_mem[1]);
    end
  endtask

  task automatic test_errors();
    int bv0;
    logic [4:0] cur0;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      do_init();
      send_byte(1'b0, 8'(8'h80 + $urandom_range(0, 15)), 1'b0);
      send_byte(1'b1, 8'(8'h30 + $urandom_range(0, 9)), 1'b0);
      send_byte(1'b1, 8'(8'h61 + $urandom_range(0, 25)), 1'b0);
      cur0 = cur_m;
      bv0 = bv_cnt;
      case (k)
        0:       send_byte(1'b0, 8'h90, 1'b0);
        1:       send_nibble(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0);
        default: begin
          send_nibble(1'b0, 1'b0, 4'h4, 1'b0);
          send_nibble(1'b1, 1'b0, 4'h1, 1'b0);
        end
      endcase
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL err_flag[%0d]: got %b want 1", k, err); end
      checks++;
      if (cursor !== cur0) begin errors++; $display("FAIL err_cursor[%0d]: got %0d want %0d", k, cursor, cur0); end
      if (k != 0) begin
        checks++;
        if (bv_cnt - bv0 != 0) begin errors++; $display("FAIL err_no_bv[%0d]: got %0d want 0", k, bv_cnt - bv0); end
      end
      dump_mem();
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (dut_mem[i] !== mem_m[i]) begin errors++; $display("FAIL err_mem[%0d][%0d]: got %h want %h", k, i, dut_mem[i], mem_m[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_byte();
    int bv0;
    do_reset();
    do_init();
    send_byte(1'b0, 8'h0C, 1'b0);
    send_byte(1'b1, 8'h48, 1'b0);
    send_nibble(1'b1, 1'b0, 4'h4, 1'b0);
    do_reset();
    checks++;
    if ({byte_valid, byte_is_data, init_done, disp_on, busy, err} !== 6'b0 ||
        last_byte !== 8'h00 || cursor !== 5'd0 || rd_char !== 8'h20) begin
      errors++; $display("FAIL rstmid_outputs: flags=%b last=%h cur=%0d rd=%h",
        {byte_valid, byte_is_data, init_done, disp_on, busy, err}, last_byte, cursor, rd_char);
    end
    dump_mem();
    checks++;
    if (dut_mem[0] !== 8'h20) begin errors++; $display("FAIL rstmid_mem: got %h want 20", dut_mem[0]); end
    bv0 = bv_cnt;
    send_nibble(1'b1, 1'b0, 4'h1, 1'b0);
    checks++;
    if (bv_cnt - bv0 != 0 || init_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_nibble: bv=%0d init=%b want 0 0", bv_cnt - bv0, init_done);
    end
    checks++;
    if (err !== err_m) begin errors++; $display("FAIL rstmid_err: got %b want %b", err, err_m); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init();
    test_line2_write();
    test_wrap_decrement();
    test_random_traffic();
    test_clear();
    test_errors();
    test_reset_mid_byte();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
